// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared constants for the TX-side system controller.
// State encodings, source selects and default widths.
package sys_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ALU_W_DEF  = 16;

   typedef logic [2:0] state_t;

   localparam state_t IDLE    = 3'd0;
   localparam state_t SEND    = 3'd1;
   localparam state_t HOLD    = 3'd2;
   localparam state_t CK_SEND = 3'd3;
   localparam state_t CK_HOLD = 3'd4;

   typedef logic src_t;

   localparam src_t SRC_RF  = 1'b0;
   localparam src_t SRC_ALU = 1'b1;

   function automatic int nbytes(input int aw, input int dw);
      return aw / dw;
   endfunction

endpackage

// File: rtl/sys_ctrl_pend_slot.sv
// sys_ctrl_pend_slot: one-entry capture slot with pending flag.
// A strobe that finds the slot pending is dropped and flagged.
module sys_ctrl_pend_slot
   import sys_ctrl_pkg::*;
#(
   parameter int W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         vld,
   input  logic         clr,
   output logic [W-1:0] dout,
   output logic         pend,
   output logic         ovr
);

   logic [W-1:0] data_q, data_d;
   logic         pend_q, pend_d;
   logic         ovr_q, ovr_d;

   // capture into a free slot, release on clr, flag dropped strobes
   always_comb begin
      data_d = data_q;
      pend_d = pend_q;
      ovr_d  = 1'b0;
      if (clr) begin
         pend_d = 1'b0;
      end
      if (vld) begin
         if (pend_q) begin
            ovr_d = 1'b1;
         end else begin
            data_d = din;
            pend_d = 1'b1;
         end
      end
   end

   // slot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   assign dout = data_q;
   assign pend = pend_q;
   assign ovr  = ovr_q;

endmodule

// File: rtl/sys_ctrl_tx_fr.sv
// sys_ctrl_tx_fr: frames RF/ALU results into UART TX bytes, LSB first.
// Define SYS_CTRL_TX_CKSUM_EN to append an XOR checksum byte per frame.
module sys_ctrl_tx_fr
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ALU_W  = ALU_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ALU_W-1:0]  ALU_OUT,
   input  logic              OUT_Valid,
   input  logic [DATA_W-1:0] RdData,
   input  logic              RdData_Valid,
   input  logic              Busy,
   output logic [DATA_W-1:0] TX_P_DATA,
   output logic              TX_D_VLD,
   output logic              clk_div_en,
   output logic              FRAME_DONE,
   output logic              OVERRUN
);

   localparam int NBYTES = nbytes(ALU_W, DATA_W);
   localparam int CW     = $clog2(NBYTES + 1);

   state_t             state_q, state_d;
   logic [ALU_W-1:0]   shift_q, shift_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               tx_vld_q, tx_vld_d;
   logic               div_en_q, div_en_d;
   logic               done_q, done_d;
`ifdef SYS_CTRL_TX_CKSUM_EN
   logic [DATA_W-1:0]  csum_q, csum_d;
`endif

   logic [DATA_W-1:0]  rf_data;
   logic [ALU_W-1:0]   alu_data;
   logic               rf_pend, alu_pend;
   logic               rf_ovr, alu_ovr;
   logic               rf_clr, alu_clr;
   logic               start, last;
   src_t               sel;

   sys_ctrl_pend_slot #(.W(DATA_W)) u_rf_slot (
      .clk  (CLK),
      .rst  (RST),
      .din  (RdData),
      .vld  (RdData_Valid),
      .clr  (rf_clr),
      .dout (rf_data),
      .pend (rf_pend),
      .ovr  (rf_ovr)
   );

   sys_ctrl_pend_slot #(.W(ALU_W)) u_alu_slot (
      .clk  (CLK),
      .rst  (RST),
      .din  (ALU_OUT),
      .vld  (OUT_Valid),
      .clr  (alu_clr),
      .dout (alu_data),
      .pend (alu_pend),
      .ovr  (alu_ovr)
   );

   // frame start arbitration: RF wins over ALU
   always_comb begin
      start   = (state_q == IDLE) && (rf_pend || alu_pend) && !Busy;
      sel     = rf_pend ? SRC_RF : SRC_ALU;
      rf_clr  = start && (sel == SRC_RF);
      alu_clr = start && (sel == SRC_ALU);
      last    = (cnt_q == CW'(1));
   end

   // state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = SEND;
         end
         SEND: begin
            if (Busy) state_d = HOLD;
         end
         HOLD: begin
            if (!Busy) begin
               if (!last) begin
                  state_d = SEND;
               end else begin
`ifdef SYS_CTRL_TX_CKSUM_EN
                  state_d = CK_SEND;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef SYS_CTRL_TX_CKSUM_EN
         CK_SEND: begin
            if (Busy) state_d = CK_HOLD;
         end
         CK_HOLD: begin
            if (!Busy) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // shift register, byte counter and checksum updates
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef SYS_CTRL_TX_CKSUM_EN
      csum_d  = csum_q;
      if (state_q == SEND && Busy) begin
         csum_d = csum_q ^ shift_q[DATA_W-1:0];
      end
`endif
      if (start) begin
         if (sel == SRC_RF) begin
            shift_d               = '0;
            shift_d[DATA_W-1:0]   = rf_data;
            cnt_d                 = CW'(1);
         end else begin
            shift_d = alu_data;
            cnt_d   = CW'(NBYTES);
         end
`ifdef SYS_CTRL_TX_CKSUM_EN
         csum_d = '0;
`endif
      end else if (state_q == HOLD && !Busy && !last) begin
         shift_d = shift_q >> DATA_W;
         cnt_d   = cnt_q - CW'(1);
      end
   end

   // registered outputs decoded from the current state
   always_comb begin
      tx_data_d = tx_data_q;
      tx_vld_d  = 1'b0;
      div_en_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
         end
         SEND: begin
            tx_vld_d  = 1'b1;
            div_en_d  = 1'b1;
            tx_data_d = shift_q[DATA_W-1:0];
         end
         HOLD: begin
            div_en_d = 1'b1;
`ifndef SYS_CTRL_TX_CKSUM_EN
            done_d   = !Busy && last;
`endif
         end
`ifdef SYS_CTRL_TX_CKSUM_EN
         CK_SEND: begin
            tx_vld_d  = 1'b1;
            div_en_d  = 1'b1;
            tx_data_d = csum_q;
         end
         CK_HOLD: begin
            div_en_d = 1'b1;
            done_d   = !Busy;
         end
`endif
         default: begin
            tx_data_d = '0;
         end
      endcase
   end

   // datapath and output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_q   <= '0;
         cnt_q     <= '0;
         tx_data_q <= '0;
         tx_vld_q  <= 1'b0;
         div_en_q  <= 1'b0;
         done_q    <= 1'b0;
`ifdef SYS_CTRL_TX_CKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_vld_q  <= tx_vld_d;
         div_en_q  <= div_en_d;
         done_q    <= done_d;
`ifdef SYS_CTRL_TX_CKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign TX_P_DATA  = tx_data_q;
   assign TX_D_VLD   = tx_vld_q;
   assign clk_div_en = div_en_q;
   assign FRAME_DONE = done_q;
   assign OVERRUN    = rf_ovr | alu_ovr;

endmodule

// File: doc/sys_ctrl_tx_fr.md
Name: sys_ctrl_tx_fr

Overview:
- Parametrised TX-side system controller between the ALU/register-file result sources and the UART TX.
- Captures results into one-entry pending slots, so a result arriving while TX is busy is not lost.
- Frames each result as ALU_W/DATA_W bytes, LSB first, with a Busy-based handshake per byte.
- Gates the TX clock divider enable.

Parameters:
- DATA_W, 8: UART byte width.
- ALU_W, 16: ALU result width; must be an integer multiple of DATA_W, at least DATA_W.
- NBYTES, ALU_W/DATA_W (derived localparam): bytes per ALU frame.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- ALU_OUT  in  ALU_W  ALU result; sampled when OUT_Valid=1.
- OUT_Valid  in  1  one-cycle ALU result strobe.
- RdData  in  DATA_W  register-file read data; sampled when RdData_Valid=1.
- RdData_Valid  in  1  one-cycle RF read strobe.
- Busy  in  1  UART TX busy.
- TX_P_DATA  out  DATA_W  byte to UART; registered.
- TX_D_VLD  out  1  byte valid; registered.
- clk_div_en  out  1  TX divider enable; registered.
- FRAME_DONE  out  1  one-cycle pulse after the last byte of a frame is accepted.
- OVERRUN  out  1  one-cycle pulse when a strobe arrives while that source's slot is already pending; the new data is dropped.

Behaviour:
- Reset (asynchronous, RST=1): all outputs 0; state IDLE; pending flags cleared; byte counter 0. Reset mid-frame aborts the frame with no further TX_D_VLD.
- Capture:
  - On a rising edge with RdData_Valid=1 and rf_pend=0: store RdData and set rf_pend.
  - Same rule for ALU_OUT/alu_pend.
  - Both strobes in the same cycle: both captured.
  - Strobe while its slot is pending: data dropped, OVERRUN=1 for the next cycle.
- State IDLE:
  - Leave when (rf_pend or alu_pend) and Busy=0.
  - RF has priority over ALU.
  - On the leaving edge: load the selected data into the shift register, clear that pending flag (the slot frees the same edge), set byte count to 1 (RF) or NBYTES (ALU), go to SEND.
  - Outputs in IDLE: clk_div_en=0, TX_D_VLD=0.
- State SEND:
  - TX_D_VLD=1; TX_P_DATA = shift[DATA_W-1:0]; clk_div_en=1.
  - Hold until Busy sampled 1, then go to HOLD.
- State HOLD:
  - TX_D_VLD=0; TX_P_DATA held; clk_div_en=1.
  - On Busy=0 with count>1: shift right by DATA_W, decrement count, go to SEND.
  - On Busy=0 with count=1: FRAME_DONE=1 next cycle, go to IDLE.
- Latency: with Busy=0 throughout, TX_D_VLD rises on the 2nd rising edge after the edge that samples the strobe.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames. A strobe arriving during a frame is served after FRAME_DONE.
- ALU_W=DATA_W: an ALU frame is a single byte.
- Busy never rising: stays in SEND indefinitely. No timeout in this revision.
- Illegal state encodings return to IDLE with outputs 0.

Optional Feature:
- Macro: SYS_CTRL_TX_CKSUM_EN.
- Defined:
  - A running XOR of all frame bytes is kept.
  - After the last data byte's HOLD, go to CK_SEND/CK_HOLD and send the checksum byte with the same handshake.
  - FRAME_DONE pulses after the checksum is accepted.
  - RF frames become 2 bytes; ALU frames become NBYTES+1 bytes.
- Undefined: no checksum states; frames as above.

Decomposition:
- Package sys_ctrl_pkg holds:
  - state encoding localparams: IDLE, SEND, HOLD, CK_SEND, CK_HOLD;
  - source-select constants SRC_RF and SRC_ALU;
  - default DATA_W/ALU_W values.
- One sub-module, sys_ctrl_pend_slot, instantiated twice (RF, ALU): valid-gated capture register, pending flag, overrun pulse, clear input.
- The FSM, shift register and counter stay in the top.

Test Plan:
- RST pulse mid-SEND of an ALU frame -> TX_D_VLD=0 asynchronously, then IDLE; no pending data survives; clk_div_en=0.
- RdData=0xA5 strobe, Busy=0 → TX_D_VLD=1 with 0xA5 two edges later; Busy high 3 cycles then low → FRAME_DONE pulse; clk_div_en back to 0.
- ALU_W=16, ALU_OUT=0x1234 → bytes 0x34 then 0x12, each held until Busy=1; a single FRAME_DONE after 0x12.
- RdData_Valid and OUT_Valid in the same cycle (0x5A, 0xBEEF) → sequence 0x5A, 0xEF, 0xBE; two FRAME_DONE pulses.
- Second OUT_Valid (0x1111) while alu_pend is set and TX is busy → OVERRUN pulse; only the first ALU value is sent.
- ALU_W=32, ALU_OUT=0x01020304 with SYS_CTRL_TX_CKSUM_EN defined → bytes 04, 03, 02, 01, then 04 (XOR); FRAME_DONE after the 5th byte.
